// File: rtl/sram_arb_ctrl.sv
// Single-port SRAM arbiter: host reads (1-cycle, never stalled), posted host writes with forwarding, engine bursts.
// Engine is backpressured through combinational eng_gnt; host writes are dropped (err_ovf) only when the buffer is full.
module sram_arb_ctrl #(
    parameter int AW        = 13,
    parameter int DW        = 32,
    parameter int DEPTH     = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   host_wr_en,
    input  logic [AW-1:0]          host_wr_addr,
    input  logic [DW-1:0]          host_wr_data,
    input  logic                   host_rd_en,
    input  logic [AW-1:0]          host_rd_addr,
    output logic [DW-1:0]          host_rd_data,
    input  logic                   eng_req,
    input  logic                   eng_we,
    input  logic [AW-1:0]          eng_addr,
    input  logic [DW-1:0]          eng_wdata,
    input  logic                   eng_last,
    output logic                   eng_gnt,
    output logic                   eng_rvalid,
    output logic [DW-1:0]          eng_rdata,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [AW-1:0]          mem_addr,
    output logic [DW-1:0]          mem_wdata,
    input  logic [DW-1:0]          mem_rdata,
    output logic [$clog2(DEPTH):0] wbuf_count,
    output logic                   err_ovf
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {IDLE, BURST, YIELD} state_t;

    state_t          state;
    logic            rr_eng;
    logic [BW-1:0]   beat_cnt;

    logic [AW-1:0]   wb_addr [DEPTH];
    logic [DW-1:0]   wb_data [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nxt;

    logic            fwd_hit;
    logic [DW-1:0]   fwd_data;
    logic            rd_fwd_q;
    logic [DW-1:0]   fwd_q;
    logic            live_q;

    logic            host_slot;
    logic            drain_pend;
    logic            urgent;
    logic            lvl3;
    logic            pick_eng;
    logic            pick_drn;
    logic            do_host;
    logic            do_drain;
    logic            do_push;

    // Walk oldest to newest so the newest matching entry wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CW'(k) < count && wb_addr[head + PW'(k)] == host_rd_addr) begin
                fwd_hit  = 1'b1;
                fwd_data = wb_data[head + PW'(k)];
            end
        end
    end

    assign host_slot  = host_rd_en && !fwd_hit;
    assign drain_pend = (count != '0);
    assign urgent     = (count >= CW'(DEPTH - 1));

    always_comb begin
        pick_eng = 1'b0;
        pick_drn = 1'b0;
        case (state)
            IDLE: begin
                if (eng_req && drain_pend) begin
                    pick_eng = rr_eng;
                    pick_drn = !rr_eng;
                end else begin
                    pick_eng = eng_req;
                    pick_drn = drain_pend;
                end
            end
            BURST: begin
                pick_eng = eng_req;
                pick_drn = !eng_req && drain_pend;
            end
            YIELD: pick_drn = drain_pend;
            default: ;
        endcase
    end

    assign do_host  = !rst && host_slot;
    assign lvl3     = !rst && !host_slot && !urgent;
    assign eng_gnt  = lvl3 && pick_eng;
    assign do_drain = (!rst && !host_slot && urgent) || (lvl3 && pick_drn);
    assign do_push  = !rst && host_wr_en && (count != CW'(DEPTH));

    always_comb begin
        count_nxt = count;
        if (do_push && !do_drain)
            count_nxt = count + CW'(1);
        else if (!do_push && do_drain)
            count_nxt = count - CW'(1);
    end

    always_comb begin
        mem_en    = do_host || do_drain || eng_gnt;
        mem_we    = do_drain || (eng_gnt && eng_we);
        mem_addr  = '0;
        mem_wdata = '0;
        if (do_host) begin
            mem_addr = host_rd_addr;
        end else if (do_drain) begin
            mem_addr  = wb_addr[head];
            mem_wdata = wb_data[head];
        end else if (eng_gnt) begin
            mem_addr  = eng_addr;
            mem_wdata = eng_we ? eng_wdata : '0;
        end
    end

    // Buffer storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            wb_addr[tail] <= host_wr_addr;
            wb_data[tail] <= host_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            err_ovf    <= 1'b0;
            state      <= IDLE;
            rr_eng     <= 1'b1;
            beat_cnt   <= '0;
            eng_rvalid <= 1'b0;
            rd_fwd_q   <= 1'b0;
            fwd_q      <= '0;
            live_q     <= 1'b0;
        end else begin
            live_q <= 1'b1;
            if (do_push)
                tail <= tail + PW'(1);
            if (do_drain)
                head <= head + PW'(1);
            count <= count_nxt;
            if (host_wr_en && count == CW'(DEPTH))
                err_ovf <= 1'b1;

            eng_rvalid <= eng_gnt && !eng_we;
            rd_fwd_q   <= host_rd_en && fwd_hit;
            if (host_rd_en && fwd_hit)
                fwd_q <= fwd_data;

            if (eng_gnt)
                rr_eng <= 1'b0;
            else if (lvl3 && pick_drn)
                rr_eng <= 1'b1;

            case (state)
                IDLE: begin
                    if (eng_gnt && !eng_last) begin
                        state    <= BURST;
                        beat_cnt <= BW'(1);
                    end
                end
                BURST: begin
                    if (eng_gnt) begin
                        beat_cnt <= beat_cnt + BW'(1);
                        if (eng_last || beat_cnt == BW'(MAX_BURST - 1))
                            state <= (count_nxt != '0) ? YIELD : IDLE;
                    end
                end
                YIELD: begin
                    // Held while host reads take the slot, so the drain is not lost.
                    if (do_drain || count == '0)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign wbuf_count   = count;
    assign eng_rdata    = eng_rvalid ? mem_rdata : '0;
    assign host_rd_data = !live_q ? '0 : (rd_fwd_q ? fwd_q : mem_rdata);

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// Bench for sram_arb_ctrl: SRAM macro model, read-data scoreboard and directed arbitration scenarios.
`timescale 1ns/1ps
module tb_sram_arb_ctrl;
    localparam int AW        = 13;
    localparam int DW        = 32;
    localparam int DEPTH     = 4;
    localparam int MAX_BURST = 16;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   host_wr_en = 1'b0;
    logic [AW-1:0]          host_wr_addr = '0;
    logic [DW-1:0]          host_wr_data = '0;
    logic                   host_rd_en = 1'b0;
    logic [AW-1:0]          host_rd_addr = '0;
    logic [DW-1:0]          host_rd_data;
    logic                   eng_req = 1'b0;
    logic                   eng_we = 1'b0;
    logic [AW-1:0]          eng_addr = '0;
    logic [DW-1:0]          eng_wdata = '0;
    logic                   eng_last = 1'b0;
    logic                   eng_gnt;
    logic                   eng_rvalid;
    logic [DW-1:0]          eng_rdata;
    logic                   mem_en;
    logic                   mem_we;
    logic [AW-1:0]          mem_addr;
    logic [DW-1:0]          mem_wdata;
    logic [DW-1:0]          mem_rdata = '0;
    logic [$clog2(DEPTH):0] wbuf_count;
    logic                   err_ovf;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    sram_arb_ctrl #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst(rst),
        .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
        .host_rd_en(host_rd_en), .host_rd_addr(host_rd_addr), .host_rd_data(host_rd_data),
        .eng_req(eng_req), .eng_we(eng_we), .eng_addr(eng_addr), .eng_wdata(eng_wdata),
        .eng_last(eng_last), .eng_gnt(eng_gnt), .eng_rvalid(eng_rvalid), .eng_rdata(eng_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .wbuf_count(wbuf_count), .err_ovf(err_ovf)
    );

    function automatic logic [DW-1:0] pat(input int a);
        return 32'hA500_0000 | 32'(a);
    endfunction

    // SRAM macro: one access per cycle, read data one cycle later
    logic [DW-1:0] sram [0:(1<<AW)-1];
    initial for (int i = 0; i < (1 << AW); i++) sram[i] = pat(i);
    always @(posedge clk) begin
        if (mem_en && mem_we)  sram[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= sram[mem_addr];
    end

    // Coherent view of memory as the host/engine expect to see it
    logic [DW-1:0] ref_mem [int];

    function automatic logic [DW-1:0] expect_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : pat(a);
    endfunction

    task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Scoreboard: expectations pushed when a read is issued, popped one cycle later
    logic [DW-1:0] host_q [$];
    logic [DW-1:0] eng_q  [$];
    logic          host_pend = 1'b0;
    logic          eng_pend  = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                host_q.delete();
                eng_q.delete();
                host_pend = 1'b0;
                eng_pend  = 1'b0;
            end else begin
                if (host_pend) check_val("host_rd_data", host_rd_data, host_q.pop_front());
                check_val("eng_rvalid", 32'(eng_rvalid), 32'(eng_pend));
                if (eng_pend) check_val("eng_rdata", eng_rdata, eng_q.pop_front());
                host_pend = host_rd_en;
                if (host_rd_en) host_q.push_back(expect_rd(int'(host_rd_addr)));
                eng_pend = eng_gnt && !eng_we;
                if (eng_pend) eng_q.push_back(pat(int'(eng_addr)));
                if (eng_gnt && eng_we) ref_mem[int'(eng_addr)] = eng_wdata;
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        host_wr_en = 1'b0;
        host_rd_en = 1'b0;
        eng_req    = 1'b0;
        eng_we     = 1'b0;
        eng_last   = 1'b0;
    endtask

    task automatic hwrite(input int a, input logic [DW-1:0] d);
        host_wr_en   = 1'b1;
        host_wr_addr = AW'(a);
        host_wr_data = d;
        ref_mem[a]   = d;
    endtask

    task automatic hread(input int a);
        host_rd_en   = 1'b1;
        host_rd_addr = AW'(a);
    endtask

    task automatic wait_empty(input string tag);
        int n = 0;
        idle_inputs();
        while (wbuf_count != '0 && n < 20) begin
            next_cycle();
            n++;
        end
        check_val(tag, 32'(wbuf_count), 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_gnt"},    32'(eng_gnt), 32'd0);
        check_val({tag, "_rvalid"}, 32'(eng_rvalid), 32'd0);
        check_val({tag, "_rdata"},  eng_rdata, 32'd0);
        check_val({tag, "_hrdata"}, host_rd_data, 32'd0);
        check_val({tag, "_mem_en"}, 32'(mem_en), 32'd0);
        check_val({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check_val({tag, "_count"},  32'(wbuf_count), 32'd0);
        check_val({tag, "_ovf"},    32'(err_ovf), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        next_cycle();
        rst = 1'b0;
        next_cycle();

        // Write then read the same address: forwarded, no SRAM read
        hwrite(32'h1A0, 32'hDEAD_BEEF);
        next_cycle();
        idle_inputs();
        hread(32'h1A0);
        @(negedge clk);
        check_val("fwd_no_sram_rd", 32'(mem_en && !mem_we), 32'd0);
        next_cycle();
        wait_empty("t1_empty");

        // Two entries to one address; host reads hold the slot so both stay buffered
        hwrite(32'h10, 32'd1); hread(32'h20);
        next_cycle();
        hwrite(32'h10, 32'd2); hread(32'h21);
        next_cycle();
        idle_inputs();
        check_val("two_entries_count", 32'(wbuf_count), 32'd2);
        hread(32'h10);
        next_cycle();
        wait_empty("t2_empty");
        hread(32'h10);
        next_cycle();
        idle_inputs();
        next_cycle();

        // Engine burst of 8 reads while two writes are posted
        eng_req = 1'b1;
        eng_we  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            eng_addr = AW'(32'h100 + i);
            eng_last = (i == 7);
            if (i < 2) hwrite(32'h200 + i, 32'h0000_2000 + 32'(i));
            @(negedge clk);
            check_val("burst8_gnt", 32'(eng_gnt), 32'd1);
            next_cycle();
            host_wr_en = 1'b0;
        end
        eng_addr = AW'(32'h108);
        eng_last = 1'b1;
        @(negedge clk);
        check_val("yield_gnt", 32'(eng_gnt), 32'd0);
        check_val("yield_drain", 32'(mem_en && mem_we), 32'd1);
        check_val("yield_addr", 32'(mem_addr), 32'h200);
        next_cycle();
        @(negedge clk);
        check_val("after_yield_gnt", 32'(eng_gnt), 32'd1);
        next_cycle();
        wait_empty("t3_empty");

        // eng_last never asserted: burst capped at MAX_BURST
        eng_req  = 1'b1;
        eng_last = 1'b0;
        for (int i = 0; i < MAX_BURST; i++) begin
            eng_addr = AW'(32'h300 + i);
            if (i < 2) hwrite(32'h210 + i, 32'h0000_3000 + 32'(i));
            @(negedge clk);
            check_val("maxb_gnt", 32'(eng_gnt), 32'd1);
            next_cycle();
            host_wr_en = 1'b0;
        end
        eng_addr = AW'(32'h310);
        @(negedge clk);
        check_val("maxb_yield_gnt", 32'(eng_gnt), 32'd0);
        check_val("maxb_yield_drain", 32'(mem_en && mem_we), 32'd1);
        next_cycle();
        eng_last = 1'b1;
        @(negedge clk);
        check_val("maxb_regrant", 32'(eng_gnt), 32'd1);
        next_cycle();
        wait_empty("t4_empty");

        // Host reads every cycle inside an engine burst
        eng_req  = 1'b1;
        eng_addr = AW'(32'h400);
        eng_last = 1'b0;
        @(negedge clk);
        check_val("hr_burst_start", 32'(eng_gnt), 32'd1);
        next_cycle();
        eng_addr = AW'(32'h401);
        for (int k = 0; k < 4; k++) begin
            hread(32'h500 + k);
            @(negedge clk);
            check_val("hr_blocks_gnt", 32'(eng_gnt), 32'd0);
            check_val("hr_mem_addr", 32'(mem_addr), 32'h500 + 32'(k));
            next_cycle();
        end
        host_rd_en = 1'b0;
        eng_last   = 1'b1;
        @(negedge clk);
        check_val("hr_burst_resume", 32'(eng_gnt), 32'd1);
        next_cycle();
        idle_inputs();

        // Single engine write, then read it back through SRAM
        eng_req   = 1'b1;
        eng_we    = 1'b1;
        eng_addr  = AW'(32'h120);
        eng_wdata = 32'h1234_5678;
        eng_last  = 1'b1;
        @(negedge clk);
        check_val("eng_wr_gnt", 32'(eng_gnt && mem_we), 32'd1);
        next_cycle();
        idle_inputs();
        hread(32'h120);
        next_cycle();
        idle_inputs();
        next_cycle();

        // Fill the buffer with reads holding the slot, then overflow
        for (int k = 0; k < DEPTH; k++) begin
            hwrite(32'h600 + k, 32'h0000_6000 + 32'(k));
            hread(32'h700 + k);
            next_cycle();
        end
        check_val("full_count", 32'(wbuf_count), 32'(DEPTH));
        check_val("full_no_ovf", 32'(err_ovf), 32'd0);
        hwrite(32'h604, 32'h0000_6004);
        hread(32'h704);
        next_cycle();
        idle_inputs();
        check_val("ovf_set", 32'(err_ovf), 32'd1);
        check_val("ovf_count", 32'(wbuf_count), 32'(DEPTH));
        rst = 1'b1;
        next_cycle();
        @(negedge clk);
        check_outputs_zero("rst2");
        next_cycle();
        rst = 1'b0;
        next_cycle();
        next_cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
